// File: rtl/configurations_pkg.sv
// Shared configuration for the vector lane memory path: default widths, element size
// and the memory-control FSM state type.
package configurations_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned VECTOR_LENGTH = 1024;
    localparam int unsigned ELEM_BYTES    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        DONE
    } mem_ctrl_state_t;

endpackage

// File: rtl/v_mem_credit_counter.sv
// Outstanding-read credit counter: one increment per granted read, one decrement per
// returned word, flagging full once MAX_OUTSTANDING reads are in flight.
module v_mem_credit_counter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CREDIT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o
);

    logic [CREDIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            // Guarded so a stray return can never wrap the count to its maximum.
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o = (count_q >= CREDIT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/v_lane_mem_ctrl.sv
// Vector lane memory controller: sequences unit-stride loads into the lane load FIFO and
// stores out of the lane store FIFO over a word-wide request/grant memory port.
module v_lane_mem_ctrl #(
    parameter int unsigned DATA_WIDTH      = configurations_pkg::DATA_WIDTH,
    parameter int unsigned VECTOR_LENGTH   = configurations_pkg::VECTOR_LENGTH,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W = $clog2(VECTOR_LENGTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  is_store_i,
    input  logic [31:0]           base_addr_i,
    input  logic [CNT_W-1:0]      vector_length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  load_fifo_we_o,
    output logic [DATA_WIDTH-1:0] load_fifo_din_o,
    input  logic                  load_fifo_almostfull_i,
    output logic                  store_fifo_re_o,
    input  logic                  store_fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] store_fifo_dout_i
);

    import configurations_pkg::*;

    mem_ctrl_state_t state_q, state_d;

    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      received_q, received_d;
    logic [CNT_W-1:0]      vl_q, vl_d;
    logic [31:0]           base_q, base_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ld_we_q, ld_we_d;

    logic credit_clear, credit_inc, credit_dec, credit_full;
    logic granted;

    assign granted = mem_req_o && mem_gnt_i;

    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        received_d      = received_q;
        vl_d            = vl_q;
        base_d          = base_q;
        rdata_d         = rdata_q;
        ld_we_d         = 1'b0;
        credit_clear    = 1'b0;
        credit_inc      = 1'b0;
        credit_dec      = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        store_fifo_re_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d       = base_addr_i;
                    vl_d         = vector_length_i;
                    issued_d     = '0;
                    received_d   = '0;
                    credit_clear = 1'b1;
                    if (vector_length_i == '0) begin
                        state_d = DONE;
                    end else if (is_store_i) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                mem_req_o = (issued_q < vl_q) && !credit_full && !load_fifo_almostfull_i;
                if (granted) begin
                    issued_d   = issued_q + 1'b1;
                    credit_inc = 1'b1;
                end
                // Returned words are registered so the FIFO write lands one cycle later.
                if (mem_rvalid_i) begin
                    rdata_d    = mem_rdata_i;
                    ld_we_d    = 1'b1;
                    received_d = received_q + 1'b1;
                    credit_dec = 1'b1;
                end
                // The final FIFO write is being driven this cycle once all words are back.
                if (received_q == vl_q) begin
                    state_d = DONE;
                end
            end

            STORE: begin
                mem_req_o       = !store_fifo_empty_i && (issued_q < vl_q);
                mem_we_o        = 1'b1;
                store_fifo_re_o = granted;
                if (granted) begin
                    issued_d = issued_q + 1'b1;
                end
                if (issued_q == vl_q) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            received_q <= '0;
            vl_q       <= '0;
            base_q     <= '0;
            rdata_q    <= '0;
            ld_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            vl_q       <= vl_d;
            base_q     <= base_d;
            rdata_q    <= rdata_d;
            ld_we_q    <= ld_we_d;
        end
    end

    v_mem_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .clear_i (credit_clear),
        .inc_i   (credit_inc),
        .dec_i   (credit_dec),
        .full_o  (credit_full)
    );

    // Address and data are forced to zero whenever no request is presented.
    assign mem_addr_o      = mem_req_o ? (base_q + 32'(issued_q) * 32'(ELEM_BYTES)) : '0;
    assign mem_wdata_o     = (mem_req_o && mem_we_o) ? store_fifo_dout_i : '0;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign load_fifo_we_o  = ld_we_q;
    assign load_fifo_din_o = rdata_q;

endmodule

// File: tb/tb_v_lane_mem_ctrl.sv
// Scoreboard bench for v_lane_mem_ctrl: a memory responder, a store FIFO model and
// queues of expected addresses/data checked as the DUT issues requests and FIFO writes.
module tb_v_lane_mem_ctrl;

    localparam int unsigned DW   = 32;
    localparam int unsigned VLEN = 1024;
    localparam int unsigned MAXO = 4;
    localparam int unsigned CW   = $clog2(VLEN) + 1;
    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i, is_store_i;
    logic [31:0]   base_addr_i;
    logic [CW-1:0] vector_length_i;
    logic          busy_o, done_o, mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          load_fifo_we_o;
    logic [DW-1:0] load_fifo_din_o;
    logic          load_fifo_almostfull_i;
    logic          store_fifo_re_o, store_fifo_empty_i;
    logic [DW-1:0] store_fifo_dout_i;

    always #5 clk = ~clk;

    v_lane_mem_ctrl #(
        .DATA_WIDTH      (DW),
        .VECTOR_LENGTH   (VLEN),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start_i                (start_i),
        .is_store_i             (is_store_i),
        .base_addr_i            (base_addr_i),
        .vector_length_i        (vector_length_i),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .mem_req_o              (mem_req_o),
        .mem_we_o               (mem_we_o),
        .mem_addr_o             (mem_addr_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_gnt_i              (mem_gnt_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rdata_i            (mem_rdata_i),
        .load_fifo_we_o         (load_fifo_we_o),
        .load_fifo_din_o        (load_fifo_din_o),
        .load_fifo_almostfull_i (load_fifo_almostfull_i),
        .store_fifo_re_o        (store_fifo_re_o),
        .store_fifo_empty_i     (store_fifo_empty_i),
        .store_fifo_dout_i      (store_fifo_dout_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] exp_raddr[$], exp_ldata[$], exp_waddr[$], exp_wdata[$], sfifo[$];
    pend_t       pend[$];

    int cyc = 0, gnt_mode = 0, lat = 2, inflight = 0, max_inflight = 0;
    int rd_gnt_cnt = 0, wr_cnt = 0, re_cnt = 0, lfwe_cnt = 0, done_cnt = 0;
    logic        prev_pend = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;

    // Memory responder, store FIFO model and scoreboard; inputs change only at negedge.
    always begin
        pend_t e;
        @(negedge clk);
        cyc++;
        mem_gnt_i = (gnt_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].data;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        store_fifo_empty_i = (sfifo.size() == 0);
        store_fifo_dout_i  = store_fifo_empty_i ? 32'hDEAD_BEEF : sfifo[0];
        #1;
        if (reset) begin
            check_eq("rst_ctl", {busy_o, done_o, mem_req_o, mem_we_o, load_fifo_we_o,
                                 store_fifo_re_o}, 0);
            check_eq("rst_addr", mem_addr_o, 0);
            check_eq("rst_data", {mem_wdata_o, load_fifo_din_o}, 0);
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                check_eq("req_hold", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, p_we, p_addr});
                if (p_we) check_eq("wdata_hold", mem_wdata_o, p_wdata);
            end
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    wr_cnt++;
                    check_eq("write_expected", 64'(exp_waddr.size() > 0), 1);
                    if (exp_waddr.size() > 0) begin
                        check_eq("write_addr", mem_addr_o, exp_waddr.pop_front());
                        check_eq("write_data", mem_wdata_o, exp_wdata.pop_front());
                    end
                end else begin
                    rd_gnt_cnt++;
                    check_eq("read_expected", 64'(exp_raddr.size() > 0), 1);
                    if (exp_raddr.size() > 0) check_eq("read_addr", mem_addr_o, exp_raddr.pop_front());
                    e.due  = cyc + lat;
                    e.data = mem_addr_o ^ RD_KEY;
                    pend.push_back(e);
                    inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                end
            end
            if (store_fifo_re_o) begin
                re_cnt++;
                if (sfifo.size() > 0) sfifo.delete(0);
            end
            if (load_fifo_we_o) begin
                lfwe_cnt++;
                check_eq("ld_expected", 64'(exp_ldata.size() > 0), 1);
                if (exp_ldata.size() > 0) check_eq("ld_data", load_fifo_din_o, exp_ldata.pop_front());
            end
            if (done_o) done_cnt++;
            prev_pend = mem_req_o && !mem_gnt_i;
            p_we      = mem_we_o;
            p_addr    = mem_addr_o;
            p_wdata   = mem_wdata_o;
        end
        if (mem_rvalid_i) begin
            pend.delete(0);
            inflight--;
        end
    end

    task automatic start_op(input logic st, input logic [31:0] base, input int vl);
        @(posedge clk); #2;
        start_i         = 1'b1;
        is_store_i      = st;
        base_addr_i     = base;
        vector_length_i = CW'(vl);
        @(posedge clk); #2;
        start_i         = 1'b0;
        is_store_i      = 1'b0;
        base_addr_i     = '0;
        vector_length_i = '0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != d0) break;
            @(posedge clk); #2;
        end
        check_eq(tag, 64'(done_cnt - d0), 1);
        check_eq("idle_after", {busy_o, done_o}, 0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("done_single", 64'(done_cnt - d0), 1);
    endtask

    task automatic run_load(input logic [31:0] base, input int vl);
        int l0, d0;
        logic [31:0] a;
        for (int i = 0; i < vl; i++) begin
            a = base + 32'(4 * i);
            exp_raddr.push_back(a);
            exp_ldata.push_back(a ^ RD_KEY);
        end
        l0 = lfwe_cnt;
        d0 = done_cnt;
        start_op(1'b0, base, vl);
        wait_done("ld_done", d0);
        check_eq("ld_words", 64'(lfwe_cnt - l0), 64'(vl));
        check_eq("ld_left", 64'(exp_ldata.size() + exp_raddr.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached, required $finish before it");
        $fatal(1);
    end

    initial begin
        int d0, r0, w0, l0, g0, hi;
        reset = 1'b1;
        start_i = 1'b0; is_store_i = 1'b0; base_addr_i = '0; vector_length_i = '0;
        load_fifo_almostfull_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        store_fifo_empty_i = 1'b1; store_fifo_dout_i = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        check_eq("idle_ctl", {busy_o, done_o, mem_req_o, load_fifo_we_o, store_fifo_re_o}, 0);
        check_eq("idle_addr", mem_addr_o, 0);

        // Load VL=8, short latency
        gnt_mode = 0; lat = 2;
        run_load(32'h0000_0100, 8);

        // Load VL=16, long latency: credit limit must be reached but never exceeded
        lat = 10; max_inflight = 0;
        run_load(32'h0000_2000, 16);
        check_eq("max_inflight", 64'(max_inflight), 64'(MAXO));

        // Store VL=5 with grant on alternate cycles
        gnt_mode = 1;
        for (int i = 0; i < 5; i++) begin
            sfifo.push_back(32'hA + 32'(i));
            exp_wdata.push_back(32'hA + 32'(i));
            exp_waddr.push_back(32'h400 + 32'(4 * i));
        end
        r0 = re_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_op(1'b1, 32'h400, 5);
        wait_done("st_done", d0);
        check_eq("st_pops", 64'(re_cnt - r0), 5);
        check_eq("st_writes", 64'(wr_cnt - w0), 5);
        check_eq("st_left", 64'(sfifo.size() + exp_waddr.size()), 0);

        // Store VL=4 with the FIFO running dry after two words
        gnt_mode = 0;
        for (int i = 0; i < 4; i++) begin
            exp_wdata.push_back(32'h1111_0000 + 32'(i));
            exp_waddr.push_back(32'h800 + 32'(4 * i));
        end
        sfifo.push_back(32'h1111_0000);
        sfifo.push_back(32'h1111_0001);
        r0 = re_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_op(1'b1, 32'h800, 4);
        for (int i = 0; i < 100; i++) begin
            if (wr_cnt - w0 >= 2) break;
            @(posedge clk); #2;
        end
        check_eq("gap_first2", 64'(wr_cnt - w0), 2);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (mem_req_o) hi++;
        end
        check_eq("gap_req", 64'(hi), 0);
        check_eq("gap_busy", busy_o, 1);
        sfifo.push_back(32'h1111_0002);
        sfifo.push_back(32'h1111_0003);
        wait_done("gap_done", d0);
        check_eq("gap_pops", 64'(re_cnt - r0), 4);
        check_eq("gap_writes", 64'(wr_cnt - w0), 4);

        // Zero-length operation: straight to DONE, no requests
        d0 = done_cnt;
        start_op(1'b0, 32'h500, 0);
        check_eq("vl0_done", {busy_o, done_o}, 2'b11);
        @(posedge clk); #2;
        check_eq("vl0_after", {busy_o, done_o, mem_req_o}, 0);
        check_eq("vl0_count", 64'(done_cnt - d0), 1);

        // Address wrap-around
        lat = 2;
        run_load(32'hFFFF_FFFC, 2);

        // Reset after three grants while read data is still returning
        lat = 3;
        for (int i = 0; i < 8; i++) begin
            exp_raddr.push_back(32'h600 + 32'(4 * i));
            exp_ldata.push_back((32'h600 + 32'(4 * i)) ^ RD_KEY);
        end
        g0 = rd_gnt_cnt; l0 = lfwe_cnt; d0 = done_cnt;
        start_op(1'b0, 32'h600, 8);
        for (int i = 0; i < 50; i++) begin
            if (rd_gnt_cnt - g0 >= 3) break;
            @(posedge clk); #2;
        end
        check_eq("rst_gnts", 64'(rd_gnt_cnt - g0), 3);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        exp_raddr.delete();
        exp_ldata.delete();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_eq("rst_no_we", 64'(lfwe_cnt - l0), 0);
        check_eq("rst_no_done", 64'(done_cnt - d0), 0);
        check_eq("rst_drained", 64'(pend.size()), 0);
        check_eq("rst_idle", {busy_o, mem_req_o}, 0);
        run_load(32'h0000_0700, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
